operand_fetch: RTL
==================

# operand_fetch

Pipeline stage between decode and execute in the RV32 core. It reads both source operands from the register file and bypasses the in-flight writeback. A 32-entry scoreboard holds back RAW/WAW hazards against instructions that have not yet written back. Results are presented to execute through a one-entry valid/ready output register.

## Interface
- XLEN, 32, datapath width
- OPW, 8, width of opaque decoded-op field passed through
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  drop output register contents (branch redirect)
- dec_valid / dec_ready  in/out  1  decode handshake
- dec_rs1, dec_rs2, dec_rd  in  5  register indices
- dec_rs1_en, dec_rs2_en, dec_rd_en  in  1  operand/destination used
- dec_imm  in  XLEN  immediate; dec_op  in  OPW  decoded op
- rf_r0_valid, rf_r1_valid  out  1  read enables; rf_r0_ad, rf_r1_ad  out  5  read addresses
- rf_r0_data, rf_r1_data  in  XLEN  combinational read data
- wb_valid  in  1; wb_ad  in  5; wb_data  in  XLEN  writeback, same bus that feeds register file write port
- ex_valid / ex_ready  out/in  1  execute handshake
- ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN; ex_op  out  OPW; ex_rd  out  5; ex_rd_en  out  1
- stall_cnt  out  32  hazard-stall cycle counter, saturating

## Operation
- rf_r0_valid = dec_valid & dec_rs1_en, rf_r0_ad = dec_rs1; port 1 likewise for rs2. Both ports driven every cycle independently.
- Operand select per source: index 0 -> 0; else wb_valid & wb_ad==rs -> wb_data (bypass); else rf data. Disabled source -> 0.
- Scoreboard busy[31:0]: set busy[rd] when ex handshake fires (ex_valid & ex_ready & ex_rd_en & ex_rd!=0); clear busy[wb_ad] on wb_valid. Same-cycle set and clear of same index: set wins. busy[0] always 0.
- Pending(r) = busy[r] | (ex_valid & ex_rd_en & ex_rd==r), masked by !(wb_valid & wb_ad==r & !(ex_valid & ex_rd_en & ex_rd==r)); r==0 never pending.
- hazard = dec_valid & ((rs1_en & Pending(rs1)) | (rs2_en & Pending(rs2)) | (rd_en & Pending(rd))). WAW check guarantees at most one outstanding writer per register.
- dec_ready = !flush & !hazard & (!ex_valid | ex_ready).
- Accept (dec_valid & dec_ready): output register loads operands, imm, op, rd, rd_en; ex_valid<=1.
- Output register states: EMPTY (ex_valid=0) -> FULL on accept; FULL -> EMPTY on ex_ready without accept; FULL -> FULL on ex_ready with accept; FULL holds (all fields stable) while !ex_ready.
- flush: ex_valid<=0 next cycle, no accept that cycle; scoreboard unchanged (instructions already in execute still write back). A handshake firing in the flush cycle still sets busy.
- stall_cnt increments each cycle hazard=1, saturates at 0xFFFF_FFFF.

## Timing
- Reset: ex_valid=0, busy=0, stall_cnt=0, all ex_* data fields 0.
- Latency: accept in cycle N -> ex_valid with data in cycle N+1.
- Throughput: one instruction per cycle when no hazard and ex_ready=1.
- Writeback clearing a busy source in cycle N allows accept in cycle N (bypass supplies data).
- Dependent back-to-back pair: second stalls until producer's wb_valid cycle, minimum bubble set by execute latency.
- dec_ready is combinational from dec_*, wb_*, ex_ready, flush; no combinational path from dec_valid to ex_valid.
- rst overrides flush and all handshakes in the same cycle.

## Structure
- Shared cpu package: XLEN, register-index width (5), OPW, and a typedef for the decoded-op bundle (op, imm, rs/rd fields and enables).
- One sub-module natural: scoreboard (busy vector, set/clear/priority, pending lookup for three indices).

## Test plan
- Reset, write x5=0x1234 via wb, issue add rs1=x5 rs2=x0 -> next cycle ex_rs1_data=0x1234, ex_rs2_data=0.
- Issue load rd=x7 (ex_ready=1), then rs1=x7 consumer -> dec_ready=0, stall_cnt counts; wb x7=0xDEAD after 3 cycles -> consumer accepted same cycle with ex_rs1_data=0xDEAD.
- ex_ready=0 for 4 cycles with FULL register -> ex_* stable, dec_ready=0, no busy bit set until handshake.
- WAW: rd=x3 producer outstanding, second rd=x3 without sources -> stalls until wb x3.
- flush while FULL and dec_valid=1 -> ex_valid=0 next cycle, no accept, busy unchanged.
- Same-cycle wb x9 and handshake with rd=x9 -> busy[9]=1 afterwards.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared core definitions for the operand-fetch stage: widths, the decoded-op
// bundle handed over by decode, and the output-register occupancy states.
package operand_fetch_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int OPW   = 8;
    localparam int NREGS = 1 << REG_W;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rs1_en;
        logic             rs2_en;
        logic             rd_en;
    } dec_op_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Register scoreboard: one busy bit per architectural register for writers
// that have left for execute but not yet written back. Also answers "is this
// register still owed a result?" for the three decode indices, folding in the
// writer sitting in the output register and a writeback arriving this cycle.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_ad,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_ad,
    input  logic             inflight_en,
    input  logic [REG_W-1:0] inflight_ad,
    input  logic [REG_W-1:0] rs1_ad,
    input  logic [REG_W-1:0] rs2_ad,
    input  logic [REG_W-1:0] rd_ad,
    output logic             rs1_pend,
    output logic             rs2_pend,
    output logic             rd_pend
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // A writer still in the output register counts as owed; a writeback only
    // releases the register when that writer is not the one in the output
    // register (the writeback then belongs to the older, retiring writer).
    function automatic logic is_pending(
        input logic [REG_W-1:0] r,
        input logic [NREGS-1:0] bv,
        input logic             inf_en,
        input logic [REG_W-1:0] inf_ad,
        input logic             wb_en,
        input logic [REG_W-1:0] wb_ad
    );
        logic inflight_hit;
        logic wb_hit;
        inflight_hit = inf_en && (inf_ad == r);
        wb_hit       = wb_en && (wb_ad == r) && !inflight_hit;
        return (r != '0) && (bv[r] || inflight_hit) && !wb_hit;
    endfunction

    // Next busy vector: clear on writeback, set on handshake (set wins), x0 never busy
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_ad] = 1'b0;
        if (set_en) busy_nxt[set_ad] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Pending lookup for the two sources and the destination
    always_comb begin
        rs1_pend = is_pending(rs1_ad, busy, inflight_en, inflight_ad, clr_en, clr_ad);
        rs2_pend = is_pending(rs2_ad, busy, inflight_en, inflight_ad, clr_en, clr_ad);
        rd_pend  = is_pending(rd_ad,  busy, inflight_en, inflight_ad, clr_en, clr_ad);
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute: reads both sources from the
// register file, bypasses the writeback bus, holds back RAW/WAW hazards via the
// scoreboard and presents the result through a one-entry output register.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_rs1_en,
    input  logic             dec_rs2_en,
    input  logic             dec_rd_en,
    input  logic [XLEN-1:0]  dec_imm,
    input  logic [OPW-1:0]   dec_op,
    output logic             rf_r0_valid,
    output logic [REG_W-1:0] rf_r0_ad,
    input  logic [XLEN-1:0]  rf_r0_data,
    output logic             rf_r1_valid,
    output logic [REG_W-1:0] rf_r1_ad,
    input  logic [XLEN-1:0]  rf_r1_data,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_ad,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [OPW-1:0]   ex_op,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_rd_en,
    output logic [31:0]      stall_cnt
);

    dec_op_t          dec_p0;
    logic             rs1_pend;
    logic             rs2_pend;
    logic             rd_pend;
    logic             hazard;
    logic             accept;
    logic             ex_fire;

    out_state_e       state_q;
    out_state_e       state_d;
    logic             vld_p1;
    logic [XLEN-1:0]  rs1_data_p1;
    logic [XLEN-1:0]  rs2_data_p1;
    logic [XLEN-1:0]  imm_p1;
    logic [OPW-1:0]   op_p1;
    logic [REG_W-1:0] rd_p1;
    logic             rd_en_p1;
    logic [31:0]      stall_cnt_q;

    // x0 and unused sources read as zero; a same-cycle writeback beats the RF
    function automatic logic [XLEN-1:0] select_operand(
        input logic             en,
        input logic [REG_W-1:0] r,
        input logic [XLEN-1:0]  rf_data,
        input logic             byp_en,
        input logic [REG_W-1:0] byp_ad,
        input logic [XLEN-1:0]  byp_data
    );
        if (!en || r == '0)           return '0;
        if (byp_en && byp_ad == r)    return byp_data;
        return rf_data;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign dec_p0 = '{op: dec_op, imm: dec_imm, rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                      rs1_en: dec_rs1_en, rs2_en: dec_rs2_en, rd_en: dec_rd_en};

    // ---- stage p0: register-file read, hazard check, handshake ----
    assign rf_r0_valid = dec_valid && dec_p0.rs1_en;
    assign rf_r0_ad    = dec_p0.rs1;
    assign rf_r1_valid = dec_valid && dec_p0.rs2_en;
    assign rf_r1_ad    = dec_p0.rs2;

    operand_fetch_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (ex_fire && rd_en_p1 && (rd_p1 != '0)),
        .set_ad      (rd_p1),
        .clr_en      (wb_valid),
        .clr_ad      (wb_ad),
        .inflight_en (vld_p1 && rd_en_p1),
        .inflight_ad (rd_p1),
        .rs1_ad      (dec_p0.rs1),
        .rs2_ad      (dec_p0.rs2),
        .rd_ad       (dec_p0.rd),
        .rs1_pend    (rs1_pend),
        .rs2_pend    (rs2_pend),
        .rd_pend     (rd_pend)
    );

    assign hazard    = dec_valid && ((dec_p0.rs1_en && rs1_pend) ||
                                     (dec_p0.rs2_en && rs2_pend) ||
                                     (dec_p0.rd_en  && rd_pend));
    assign dec_ready = !flush && !hazard && (!vld_p1 || ex_ready);
    assign accept    = dec_valid && dec_ready;
    assign ex_fire   = vld_p1 && ex_ready;

    // Output register occupancy state
    always_ff @(posedge clk) begin
        if (rst) state_q <= OUT_EMPTY;
        else     state_q <= state_d;
    end

    // Occupancy next state: flush empties, accept fills, consumption empties
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (accept) state_d = OUT_FULL;
            OUT_FULL: begin
                if (flush)                     state_d = OUT_EMPTY;
                else if (ex_ready && !accept)  state_d = OUT_EMPTY;
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // Valid to execute follows occupancy
    always_comb vld_p1 = (state_q == OUT_FULL);

    // ---- stage p1: output register payload ----
    // Payload captured on accept and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            op_p1       <= '0;
            rd_p1       <= '0;
            rd_en_p1    <= 1'b0;
        end else if (accept) begin
            rs1_data_p1 <= select_operand(dec_p0.rs1_en, dec_p0.rs1, rf_r0_data, wb_valid, wb_ad, wb_data);
            rs2_data_p1 <= select_operand(dec_p0.rs2_en, dec_p0.rs2, rf_r1_data, wb_valid, wb_ad, wb_data);
            imm_p1      <= dec_p0.imm;
            op_p1       <= dec_p0.op;
            rd_p1       <= dec_p0.rd;
            rd_en_p1    <= dec_p0.rd_en;
        end
    end

    // Saturating count of cycles spent on a hazard
    always_ff @(posedge clk) begin
        if (rst)         stall_cnt_q <= '0;
        else if (hazard) stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    assign ex_valid    = vld_p1;
    assign ex_rs1_data = rs1_data_p1;
    assign ex_rs2_data = rs2_data_p1;
    assign ex_imm      = imm_p1;
    assign ex_op       = op_p1;
    assign ex_rd       = rd_p1;
    assign ex_rd_en    = rd_en_p1;
    assign stall_cnt   = stall_cnt_q;

endmodule
